// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, opcode/func and ALU encodings for multicycle_ctrl
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_I_EXEC   = 4'd8,
      S_I_WB     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL      = 4'd12,
      S_EXC      = 4'd13
   } state_t;

   typedef enum logic [1:0] {
      CLS_ADD    = 2'd0,
      CLS_BRANCH = 2'd1,
      CLS_RTYPE  = 2'd2,
      CLS_ITYPE  = 2'd3
   } alu_cls_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SRLV = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_NOR  = 3'b101;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   function automatic logic func_known(input logic [5:0] fn);
      case (fn)
         FN_SRLV, FN_ADD, FN_SUB, FN_AND,
         FN_OR, FN_XOR, FN_NOR, FN_SLT: func_known = 1'b1;
         default:                       func_known = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - ALU operation select from state class and the latched opcode/func
module mc_alu_decode
   import mc_ctrl_pkg::*;
#(
   parameter int ALU_SEL_W = 3
) (
   input  alu_cls_t               i_cls,
   input  logic [5:0]             i_opcode,
   input  logic [5:0]             i_func,
   output logic [ALU_SEL_W-1:0]   o_alu_sel
);

   logic [2:0] w_sel;

   always_comb begin
      w_sel = ALU_ADD;
      case (i_cls)
         CLS_BRANCH: w_sel = ALU_SUB;
         CLS_RTYPE: begin
            case (i_func)
               FN_AND:  w_sel = ALU_AND;
               FN_OR:   w_sel = ALU_OR;
               FN_SRLV: w_sel = ALU_SRLV;
               FN_XOR:  w_sel = ALU_XOR;
               FN_NOR:  w_sel = ALU_NOR;
               FN_SUB:  w_sel = ALU_SUB;
               FN_SLT:  w_sel = ALU_SLT;
               default: w_sel = ALU_ADD;
            endcase
         end
         CLS_ITYPE: begin
            case (i_opcode)
               OP_ANDI: w_sel = ALU_AND;
               OP_ORI:  w_sel = ALU_OR;
               OP_SLTI: w_sel = ALU_SLT;
               default: w_sel = ALU_ADD;
            endcase
         end
         default: w_sel = ALU_ADD;
      endcase
   end

   // Wider selects carry the 3-bit code in the LSBs with zeros above.
   always_comb begin
      o_alu_sel      = '0;
      o_alu_sel[2:0] = w_sel;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM with memory wait and illegal-instruction trap
module multicycle_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int ALU_SEL_W    = 3,
   parameter bit HAS_MEM_WAIT = 1'b1,
   parameter bit EXC_EN       = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 zero,
   input  logic [5:0]           opcode,
   input  logic [5:0]           func,
   input  logic                 mem_ready,
   output logic                 IorD,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 MemtoReg,
   output logic                 IRWrite,
   output logic                 RegWrite,
   output logic                 ALUSrcA,
   output logic                 ExtZero,
   output logic [1:0]           RegDst,
   output logic                 WDSel,
   output logic                 PCEn,
   output logic [1:0]           PCSource,
   output logic [1:0]           ALUSrcB,
   output logic [ALU_SEL_W-1:0] ALUSel,
   output logic                 exc,
   output logic [3:0]           curr_state
);

   localparam state_t ILL_STATE = EXC_EN ? S_EXC : S_FETCH;

   state_t     r_state;
   logic [5:0] r_op;
   logic [5:0] r_func;
   logic       r_is_bne;

   logic       w_rdy;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_reg_write;
   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic       w_exc;
   alu_cls_t   w_cls;

   assign w_rdy      = HAS_MEM_WAIT ? mem_ready : 1'b1;
   assign curr_state = r_state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_FETCH;
         r_op     <= '0;
         r_func   <= '0;
         r_is_bne <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH:    if (w_rdy) r_state <= S_DECODE;
            S_DECODE: begin
               // The instruction is latched here; later states never look at opcode/func.
               r_op     <= opcode;
               r_func   <= func;
               r_is_bne <= (opcode == OP_BNE);
               case (opcode)
                  OP_RTYPE:                          r_state <= func_known(func) ? S_R_EXEC : ILL_STATE;
                  OP_LW, OP_SW:                      r_state <= S_MEM_ADDR;
                  OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: r_state <= S_I_EXEC;
                  OP_BEQ, OP_BNE:                    r_state <= S_BRANCH;
                  OP_J:                              r_state <= S_JUMP;
                  OP_JAL:                            r_state <= S_JAL;
                  default:                           r_state <= ILL_STATE;
               endcase
            end
            S_MEM_ADDR: r_state <= (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (w_rdy) r_state <= S_MEM_WB;
            S_MEM_WR:   if (w_rdy) r_state <= S_FETCH;
            S_R_EXEC:   r_state <= S_R_WB;
            S_I_EXEC:   r_state <= S_I_WB;
            default:    r_state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_reg_write     = 1'b0;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_exc           = 1'b0;
      IorD            = 1'b0;
      MemtoReg        = 1'b0;
      ALUSrcA         = 1'b0;
      ExtZero         = 1'b0;
      WDSel           = 1'b0;
      RegDst          = 2'b00;
      PCSource        = 2'b00;
      ALUSrcB         = 2'b01;
      w_cls           = CLS_ADD;
      case (r_state)
         S_FETCH: begin
            w_mem_read = 1'b1;
            w_ir_write = w_rdy;
            w_pc_write = w_rdy;
         end
         S_DECODE:   ALUSrcB = 2'b11;
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEM_RD: begin
            w_mem_read = 1'b1;
            IorD       = 1'b1;
         end
         S_MEM_WB: begin
            w_reg_write = 1'b1;
            MemtoReg    = 1'b1;
         end
         S_MEM_WR: begin
            w_mem_write = 1'b1;
            IorD        = 1'b1;
         end
         S_R_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b00;
            w_cls   = CLS_RTYPE;
         end
         S_R_WB: begin
            w_reg_write = 1'b1;
            RegDst      = 2'b01;
         end
         S_I_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ExtZero = (r_op == OP_ANDI) || (r_op == OP_ORI);
            w_cls   = CLS_ITYPE;
         end
         S_I_WB:     w_reg_write = 1'b1;
         S_BRANCH: begin
            ALUSrcA         = 1'b1;
            ALUSrcB         = 2'b00;
            PCSource        = 2'b01;
            w_pc_write_cond = 1'b1;
            w_cls           = CLS_BRANCH;
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            PCSource   = 2'b10;
         end
         S_JAL: begin
            w_pc_write  = 1'b1;
            PCSource    = 2'b10;
            w_reg_write = 1'b1;
            RegDst      = 2'b10;
            WDSel       = 1'b1;
         end
         S_EXC: begin
            w_exc      = 1'b1;
            w_pc_write = 1'b1;
            PCSource   = 2'b11;
         end
         default: ;
      endcase
   end

   // Enables are gated by rst directly so a mid-instruction reset kills them in the same cycle.
   assign MemRead  = rst & w_mem_read;
   assign MemWrite = rst & w_mem_write;
   assign IRWrite  = rst & w_ir_write;
   assign RegWrite = rst & w_reg_write;
   assign exc      = rst & w_exc;
   assign PCEn     = rst & (w_pc_write | (w_pc_write_cond & (zero ^ r_is_bne)));

   mc_alu_decode #(
      .ALU_SEL_W (ALU_SEL_W)
   ) u_alu_decode (
      .i_cls     (w_cls),
      .i_opcode  (r_op),
      .i_func    (r_func),
      .o_alu_sel (ALUSel)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl, trap and no-trap builds side by side
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] func = '0;

   logic a_IorD, a_MemRead, a_MemWrite, a_MemtoReg, a_IRWrite, a_RegWrite, a_ALUSrcA, a_ExtZero;
   logic a_WDSel, a_PCEn, a_exc;
   logic [1:0] a_RegDst, a_PCSource, a_ALUSrcB;
   logic [2:0] a_ALUSel;
   logic [3:0] a_state;
   logic b_IorD, b_MemRead, b_MemWrite, b_MemtoReg, b_IRWrite, b_RegWrite, b_ALUSrcA, b_ExtZero;
   logic b_WDSel, b_PCEn, b_exc;
   logic [1:0] b_RegDst, b_PCSource, b_ALUSrcB;
   logic [2:0] b_ALUSel;
   logic [3:0] b_state;

   always #5 clk = ~clk;

   multicycle_ctrl #(.ALU_SEL_W(3), .HAS_MEM_WAIT(1'b1), .EXC_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .zero(zero), .opcode(opcode), .func(func), .mem_ready(mem_ready),
      .IorD(a_IorD), .MemRead(a_MemRead), .MemWrite(a_MemWrite), .MemtoReg(a_MemtoReg),
      .IRWrite(a_IRWrite), .RegWrite(a_RegWrite), .ALUSrcA(a_ALUSrcA), .ExtZero(a_ExtZero),
      .RegDst(a_RegDst), .WDSel(a_WDSel), .PCEn(a_PCEn), .PCSource(a_PCSource),
      .ALUSrcB(a_ALUSrcB), .ALUSel(a_ALUSel), .exc(a_exc), .curr_state(a_state)
   );

   multicycle_ctrl #(.ALU_SEL_W(3), .HAS_MEM_WAIT(1'b1), .EXC_EN(1'b0)) u_dut_noexc (
      .clk(clk), .rst(rst), .zero(zero), .opcode(opcode), .func(func), .mem_ready(mem_ready),
      .IorD(b_IorD), .MemRead(b_MemRead), .MemWrite(b_MemWrite), .MemtoReg(b_MemtoReg),
      .IRWrite(b_IRWrite), .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA), .ExtZero(b_ExtZero),
      .RegDst(b_RegDst), .WDSel(b_WDSel), .PCEn(b_PCEn), .PCSource(b_PCSource),
      .ALUSrcB(b_ALUSrcB), .ALUSel(b_ALUSel), .exc(b_exc), .curr_state(b_state)
   );

   // {MemRead,MemWrite,IRWrite,RegWrite,PCEn,exc,IorD,MemtoReg,ALUSrcA,ExtZero,WDSel,RegDst,PCSource,ALUSrcB,ALUSel}
   logic [19:0] a_vec, b_vec;
   assign a_vec = {a_MemRead, a_MemWrite, a_IRWrite, a_RegWrite, a_PCEn, a_exc, a_IorD, a_MemtoReg,
                   a_ALUSrcA, a_ExtZero, a_WDSel, a_RegDst, a_PCSource, a_ALUSrcB, a_ALUSel};
   assign b_vec = {b_MemRead, b_MemWrite, b_IRWrite, b_RegWrite, b_PCEn, b_exc, b_IorD, b_MemtoReg,
                   b_ALUSrcA, b_ExtZero, b_WDSel, b_RegDst, b_PCSource, b_ALUSrcB, b_ALUSel};

   typedef enum {ST_RESET, ST_FWAIT, ST_FETCH, ST_DECODE, ST_MADDR, ST_MRD, ST_MWB, ST_MWR,
                 ST_REXE, ST_RWB, ST_IEXE, ST_IWB, ST_BR, ST_J, ST_JAL, ST_EXC} step_t;
   typedef enum {C_R, C_LW, C_SW, C_I, C_BR, C_J, C_JAL, C_ILL} class_t;
   typedef struct {
      string       tag;
      logic [19:0] v;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   total = 0;
   int   bad = 0;

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic class_t classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00: begin
            case (fn)
               6'h06, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: return C_R;
               default: return C_ILL;
            endcase
         end
         6'h23: return C_LW;
         6'h2B: return C_SW;
         6'h08, 6'h0A, 6'h0C, 6'h0D: return C_I;
         6'h04, 6'h05: return C_BR;
         6'h02: return C_J;
         6'h03: return C_JAL;
         default: return C_ILL;
      endcase
   endfunction

   function automatic logic [2:0] alu_code(input string name);
      case (name)
         "AND": return 3'b000;
         "OR":  return 3'b001;
         "ADD": return 3'b010;
         "SRLV": return 3'b011;
         "XOR": return 3'b100;
         "NOR": return 3'b101;
         "SUB": return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   function automatic string r_name(input logic [5:0] fn);
      case (fn)
         6'h06: return "SRLV";
         6'h20: return "ADD";
         6'h22: return "SUB";
         6'h24: return "AND";
         6'h25: return "OR";
         6'h26: return "XOR";
         6'h27: return "NOR";
         default: return "SLT";
      endcase
   endfunction

   function automatic string i_name(input logic [5:0] op);
      case (op)
         6'h08: return "ADD";
         6'h0A: return "SLT";
         6'h0C: return "AND";
         default: return "OR";
      endcase
   endfunction

   // Expected control word for one flow step; anything not named keeps the FETCH mux values.
   function automatic logic [19:0] ref_out(input step_t s, input logic [5:0] op, input logic [5:0] fn, input logic z);
      logic mr = 0, mw = 0, irw = 0, rw = 0, pcen = 0, ex = 0, iord = 0, m2r = 0, asa = 0, ez = 0, wds = 0;
      logic [1:0] rd = 2'b00, pcs = 2'b00, asb = 2'b01;
      logic [2:0] alu = alu_code("ADD");
      case (s)
         ST_FWAIT:  mr = 1;
         ST_FETCH:  begin mr = 1; irw = 1; pcen = 1; end
         ST_DECODE: asb = 2'b11;
         ST_MADDR:  begin asa = 1; asb = 2'b10; end
         ST_MRD:    begin mr = 1; iord = 1; end
         ST_MWB:    begin rw = 1; m2r = 1; end
         ST_MWR:    begin mw = 1; iord = 1; end
         ST_REXE:   begin asa = 1; asb = 2'b00; alu = alu_code(r_name(fn)); end
         ST_RWB:    begin rw = 1; rd = 2'b01; end
         ST_IEXE:   begin asa = 1; asb = 2'b10; alu = alu_code(i_name(op)); ez = (op == 6'h0C || op == 6'h0D); end
         ST_IWB:    rw = 1;
         ST_BR:     begin asa = 1; asb = 2'b00; alu = alu_code("SUB"); pcs = 2'b01; pcen = (op == 6'h05) ? !z : z; end
         ST_J:      begin pcen = 1; pcs = 2'b10; end
         ST_JAL:    begin pcen = 1; pcs = 2'b10; rw = 1; rd = 2'b10; wds = 1; end
         ST_EXC:    begin ex = 1; pcen = 1; pcs = 2'b11; end
         default: ;
      endcase
      return {mr, mw, irw, rw, pcen, ex, iord, m2r, asa, ez, wds, rd, pcs, asb, alu};
   endfunction

   task automatic drive(input step_t s1, input step_t s2, input logic [5:0] op, input logic [5:0] fn,
                        input logic real_ir, input logic rdy, input logic z, input logic rs);
      exp_t e;
      @(posedge clk);
      #1;
      rst       = rs;
      mem_ready = rdy;
      zero      = z;
      opcode    = real_ir ? op : 6'($urandom);
      func      = real_ir ? fn : 6'($urandom);
      e.tag = $sformatf("%s op=%02h fn=%02h z=%0b", s1.name(), op, fn, z);
      e.v   = ref_out(s1, op, fn, z);
      q1.push_back(e);
      e.tag = $sformatf("%s op=%02h fn=%02h z=%0b", s2.name(), op, fn, z);
      e.v   = ref_out(s2, op, fn, z);
      q2.push_back(e);
   endtask

   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fw, input int mw);
      for (int i = 0; i < fw; i++) drive(ST_FWAIT, ST_FWAIT, op, fn, 0, 0, rb(), 1);
      drive(ST_FETCH, ST_FETCH, op, fn, 0, 1, rb(), 1);
      drive(ST_DECODE, ST_DECODE, op, fn, 1, rb(), rb(), 1);
      case (classify(op, fn))
         C_R:  begin drive(ST_REXE, ST_REXE, op, fn, 0, rb(), rb(), 1); drive(ST_RWB, ST_RWB, op, fn, 0, rb(), rb(), 1); end
         C_I:  begin drive(ST_IEXE, ST_IEXE, op, fn, 0, rb(), rb(), 1); drive(ST_IWB, ST_IWB, op, fn, 0, rb(), rb(), 1); end
         C_LW: begin
            drive(ST_MADDR, ST_MADDR, op, fn, 0, rb(), rb(), 1);
            for (int i = 0; i < mw; i++) drive(ST_MRD, ST_MRD, op, fn, 0, 0, rb(), 1);
            drive(ST_MRD, ST_MRD, op, fn, 0, 1, rb(), 1);
            drive(ST_MWB, ST_MWB, op, fn, 0, rb(), rb(), 1);
         end
         C_SW: begin
            drive(ST_MADDR, ST_MADDR, op, fn, 0, rb(), rb(), 1);
            for (int i = 0; i < mw; i++) drive(ST_MWR, ST_MWR, op, fn, 0, 0, rb(), 1);
            drive(ST_MWR, ST_MWR, op, fn, 0, 1, rb(), 1);
         end
         C_BR:  drive(ST_BR, ST_BR, op, fn, 0, rb(), z, 1);
         C_J:   drive(ST_J, ST_J, op, fn, 0, rb(), rb(), 1);
         C_JAL: drive(ST_JAL, ST_JAL, op, fn, 0, rb(), rb(), 1);
         // No-trap build is already back in FETCH; holding mem_ready low keeps both builds aligned.
         default: drive(ST_EXC, ST_FWAIT, op, fn, 0, 0, rb(), 1);
      endcase
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            total++;
            if (a_vec !== e.v) begin
               bad++;
               $display("FAIL trap_build %s: got %05h want %05h", e.tag, a_vec, e.v);
            end
         end
         if (q2.size() != 0) begin
            e = q2.pop_front();
            total++;
            if (b_vec !== e.v) begin
               bad++;
               $display("FAIL notrap_build %s: got %05h want %05h", e.tag, b_vec, e.v);
            end
         end
      end
   end

   logic [5:0] op_tab [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                               6'h23, 6'h2B, 6'h3F, 6'h01, 6'h10};
   logic [5:0] fn_tab [11] = '{6'h06, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                               6'h00, 6'h21, 6'h3F};

   initial begin
      logic [5:0] op, fn;
      for (int i = 0; i < 3; i++) drive(ST_RESET, ST_RESET, 6'h00, 6'h00, 0, rb(), rb(), 0);
      issue(6'h00, 6'h06, 0, 0, 0);
      issue(6'h23, 6'h00, 0, 2, 1);
      issue(6'h05, 6'h00, 0, 0, 0);
      issue(6'h05, 6'h00, 1, 0, 0);
      issue(6'h04, 6'h00, 1, 0, 0);
      issue(6'h04, 6'h00, 0, 0, 0);
      issue(6'h03, 6'h00, 0, 0, 0);
      issue(6'h3F, 6'h00, 0, 0, 0);
      issue(6'h00, 6'h3F, 0, 1, 0);
      issue(6'h0C, 6'h00, 0, 0, 0);

      // sw interrupted by reset while waiting in MEM_WR
      drive(ST_FETCH, ST_FETCH, 6'h2B, 6'h00, 0, 1, rb(), 1);
      drive(ST_DECODE, ST_DECODE, 6'h2B, 6'h00, 1, rb(), rb(), 1);
      drive(ST_MADDR, ST_MADDR, 6'h2B, 6'h00, 0, rb(), rb(), 1);
      drive(ST_MWR, ST_MWR, 6'h2B, 6'h00, 0, 0, rb(), 1);
      drive(ST_RESET, ST_RESET, 6'h2B, 6'h00, 0, rb(), rb(), 0);
      drive(ST_RESET, ST_RESET, 6'h2B, 6'h00, 0, rb(), rb(), 0);

      for (int n = 0; n < 300; n++) begin
         op = op_tab[$urandom_range(0, 13)];
         fn = (op == 6'h00) ? fn_tab[$urandom_range(0, 10)] : 6'($urandom);
         issue(op, fn, rb(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end

      @(negedge clk);
      #1;
      total++;
      if (q1.size() != 0 || q2.size() != 0) begin
         bad++;
         $display("FAIL queue_drain: left %0d/%0d want 0/0", q1.size(), q2.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
